// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and link constants
// common to the receiver and transmitter.
package uart_pkg;

  localparam int UART_OS_RATE   = 16;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is chosen per use so the synchronized level matches the line's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx16.sv
// 8N1 UART receiver driven by an oversampling tick; recovers LSB-first
// bytes and reports ready, framing-error and overrun flags.
module uart_rx16
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OS_RATE   = UART_OS_RATE
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SMP_W  = $clog2(OS_RATE);
  localparam int BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(OS_RATE - 1);
  localparam logic [SMP_W-1:0]  SMP_MID   = SMP_W'(OS_RATE / 2 - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [SMP_W-1:0]     r_smp;
  logic [BIDX_W-1:0]    r_bidx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_fe;
  logic                 r_ovr;
  logic                 w_shift;
  logic                 w_stop_good;
  logic                 w_stop_bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .i_clk (clk_50m),
    .i_rst (rst),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_smp   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (rxclk_en) begin
        case (r_state)
          IDLE: r_smp <= '0;
          START: begin
            if (r_smp == SMP_MID) begin
              r_smp  <= '0;
              r_bidx <= '0;
            end else begin
              r_smp <= r_smp + 1'b1;
            end
          end
          // OS_RATE is a power of two, so the counter wraps to 0 by itself
          default: r_smp <= r_smp + 1'b1;
        endcase
        if (w_shift) begin
          r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
          r_bidx  <= r_bidx + 1'b1;
        end
      end
      if (rdy_clr) begin
        r_rdy <= 1'b0;
        r_ovr <= 1'b0;
      end
      // A good load overrides a coincident clear
      if (w_stop_good) begin
        r_data <= r_shreg;
        r_rdy  <= 1'b1;
        r_fe   <= 1'b0;
        if (r_rdy && !rdy_clr) r_ovr <= 1'b1;
      end else if (w_stop_bad) begin
        r_fe <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (rxclk_en) begin
      case (r_state)
        IDLE:    if (!w_rx_s) w_state_nxt = START;
        START: begin
          if (w_rx_s)                w_state_nxt = IDLE;
          else if (r_smp == SMP_MID) w_state_nxt = DATA;
        end
        DATA:    if (w_shift && (r_bidx == BIDX_LAST)) w_state_nxt = STOP;
        STOP:    if (r_smp == SMP_LAST) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift     = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    if (rxclk_en && (r_smp == SMP_LAST)) begin
      if (r_state == DATA) w_shift = 1'b1;
      if (r_state == STOP) begin
        w_stop_good = w_rx_s;
        w_stop_bad  = !w_rx_s;
      end
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_fe;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx16.sv
// Self-checking bench for uart_rx16: frames are driven bit-serially at 64
// clocks per bit and results compared with a frame-level scoreboard.
module tb_uart_rx16;
  import uart_pkg::*;

  localparam int BIT_CLKS = 4 * UART_OS_RATE;
  localparam int FRAME    = 10 * BIT_CLKS;
  // Clock index (from the start-bit drive) of the edge that loads a frame:
  // 2 sync cycles + half a bit of ticks + 9 full bits.
  localparam int LOAD_N   = 2 + 4 * (UART_OS_RATE / 2) + 9 * BIT_CLKS;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rxclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int ph = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_rdy = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_post = 1'b0;
  logic       rdy_at_pre;
  logic       rdy_at_post;

  always #10 clk_50m = ~clk_50m;

  uart_rx16 dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic cyc();
    @(negedge clk_50m);
    ph++;
    rxclk_en = ((ph % 4) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Phase the start bit so the tick lands right as rx_s first goes low.
  task automatic align();
    cyc();
    while ((ph % 4) != 2) cyc();
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok, input int clr_at);
    if (clr_at >= 0 && clr_at < LOAD_N) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
    if (ok) begin
      m_ovr  = (clr_at == LOAD_N) ? 1'b0 : (m_ovr | m_rdy);
      m_rdy  = 1'b1;
      m_data = b;
      m_fe   = 1'b0;
    end else begin
      m_fe = 1'b1;
      if (clr_at == LOAD_N) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    m_post = m_rdy;
    if (clr_at > LOAD_N) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int clr_at);
    align();
    for (int n = 0; n < FRAME; n++) begin
      if (n > 0) cyc();
      if (n < BIT_CLKS)          rx = 1'b0;
      else if (n < 9 * BIT_CLKS) rx = b[(n / BIT_CLKS) - 1];
      // A bad stop is low across its centre only, then the line idles again
      else rx = stop_ok ? 1'b1 : ((n < 9 * BIT_CLKS + 48) ? 1'b0 : 1'b1);
      rdy_clr = (n == clr_at);
      if (n == LOAD_N)     rdy_at_pre  = rdy;
      if (n == LOAD_N + 1) rdy_at_post = rdy;
    end
    model_frame(b, stop_ok, clr_at);
  endtask

  task automatic pulse_clr();
    cyc();
    rdy_clr = 1'b1;
    cyc();
    rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1);
    checks++; if (rdy_at_pre !== 1'b0) begin failures++; $display("FAIL a5_rdy_early got=%b exp=0", rdy_at_pre); end
    checks++; if (rdy_at_post !== 1'b1) begin failures++; $display("FAIL a5_rdy_latency got=%b exp=1", rdy_at_post); end
    checks++; if (data !== m_data) begin failures++; $display("FAIL a5_data got=%h exp=%h", data, m_data); end
    checks++; if (frame_err !== m_fe) begin failures++; $display("FAIL a5_fe got=%b exp=%b", frame_err, m_fe); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL a5_ovr got=%b exp=%b", overrun, m_ovr); end
    pulse_clr();
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL a5_clr_rdy got=%b exp=%b", rdy, m_rdy); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, LOAD_N + 10);
    checks++; if (data !== m_data) begin failures++; $display("FAIL b2b0_data got=%h exp=%h", data, m_data); end
    checks++; if (rdy_at_post !== 1'b1) begin failures++; $display("FAIL b2b0_rdy got=%b exp=1", rdy_at_post); end
    send_frame(8'hFF, 1'b1, LOAD_N + 10);
    checks++; if (data !== m_data) begin failures++; $display("FAIL b2b1_data got=%h exp=%h", data, m_data); end
    checks++; if (rdy_at_post !== 1'b1) begin failures++; $display("FAIL b2b1_rdy got=%b exp=1", rdy_at_post); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL b2b_ovr got=%b exp=%b", overrun, m_ovr); end
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL b2b_clr_rdy got=%b exp=%b", rdy, m_rdy); end
  endtask

  task automatic test_glitch();
    align();
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL glitch_rdy got=%b exp=%b", rdy, m_rdy); end
    checks++; if (data !== m_data) begin failures++; $display("FAIL glitch_data got=%h exp=%h", data, m_data); end
    checks++; if (frame_err !== m_fe) begin failures++; $display("FAIL glitch_fe got=%b exp=%b", frame_err, m_fe); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, -1);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_fe got=%b exp=1", frame_err); end
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL ferr_rdy got=%b exp=%b", rdy, m_rdy); end
    checks++; if (data !== m_data) begin failures++; $display("FAIL ferr_data got=%h exp=%h", data, m_data); end
    send_frame(8'h11, 1'b1, -1);
    checks++; if (frame_err !== m_fe) begin failures++; $display("FAIL ferr_recover_fe got=%b exp=%b", frame_err, m_fe); end
    checks++; if (data !== m_data) begin failures++; $display("FAIL ferr_recover_data got=%h exp=%h", data, m_data); end
    pulse_clr();
  endtask

  task automatic test_overrun();
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'h66, 1'b1, -1);
    checks++; if (data !== m_data) begin failures++; $display("FAIL ovr_data got=%h exp=%h", data, m_data); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ovr_rdy got=%b exp=1", rdy); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", overrun, m_ovr); end
    pulse_clr();
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL ovr_clr_rdy got=%b exp=%b", rdy, m_rdy); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_clr_flag got=%b exp=%b", overrun, m_ovr); end
    send_frame(8'h77, 1'b1, -1);
    send_frame(8'h88, 1'b1, LOAD_N);
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL coinc_rdy got=%b exp=%b", rdy, m_rdy); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL coinc_ovr got=%b exp=%b", overrun, m_ovr); end
    checks++; if (data !== m_data) begin failures++; $display("FAIL coinc_data got=%h exp=%h", data, m_data); end
    pulse_clr();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         ok;
    int         clr_at;
    int         sel;
    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      clr_at = (sel == 0) ? -1 : (sel == 1) ? LOAD_N - 10 : (sel == 2) ? LOAD_N : LOAD_N + 10;
      send_frame(b, ok, clr_at);
      checks++; if (data !== m_data) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", i, data, m_data); end
      checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL rnd%0d_rdy got=%b exp=%b", i, rdy, m_rdy); end
      checks++; if (frame_err !== m_fe) begin failures++; $display("FAIL rnd%0d_fe got=%b exp=%b", i, frame_err, m_fe); end
      checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rnd%0d_ovr got=%b exp=%b", i, overrun, m_ovr); end
      checks++; if (rdy_at_post !== m_post) begin failures++; $display("FAIL rnd%0d_rdy_load got=%b exp=%b", i, rdy_at_post, m_post); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h5A;
    send_frame(8'hC3, 1'b1, -1);
    align();
    for (int n = 0; n < 5 * BIT_CLKS + BIT_CLKS / 2; n++) begin
      if (n > 0) cyc();
      rx = (n < BIT_CLKS) ? 1'b0 : b[(n / BIT_CLKS) - 1];
    end
    rst = 1'b1;
    cyc();
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rstmid_rdy got=%b exp=0", rdy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_fe got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
    idle(3);
    rx  = 1'b1;
    rst = 1'b0;
    m_data = 8'h00;
    m_rdy  = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    idle(2 * BIT_CLKS);
    send_frame(8'h81, 1'b1, -1);
    checks++; if (data !== m_data) begin failures++; $display("FAIL post_rst_data got=%h exp=%h", data, m_data); end
    checks++; if (rdy !== m_rdy) begin failures++; $display("FAIL post_rst_rdy got=%b exp=%b", rdy, m_rdy); end
    checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL post_rst_ovr got=%b exp=%b", overrun, m_ovr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx16.md
# uart_rx16

Serial receiver for the UART link: takes the asynchronous `rx` line and the 16×-oversampling enable produced by the baud-rate generator, and recovers 8N1 bytes. It is the consumer of that generator's `Rxclk_en` tick. It sits between the pad and the bus-side UART register logic, and presents each byte with a ready flag and error flags.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, LSB first.
- `OS_RATE`, default 16: ticks per bit; must be a power of two ≥ 8.
- `clk_50m`  input  1: system clock, 50 MHz, the only clock.
- `rst`  input  1: asynchronous, active-high reset.
- `rxclk_en`  input  1: oversample tick, one `clk_50m` cycle wide, `OS_RATE` ticks per bit period.
- `rx`  input  1: serial line, idle high, asynchronous to `clk_50m`.
- `rdy_clr`  input  1: single-cycle pulse that clears `rdy` and `overrun`.
- `data`  output  DATA_BITS: last good byte.
- `rdy`  output  1: byte available; sticky until `rdy_clr`.
- `frame_err`  output  1: the last frame had a low stop bit; cleared by the next good frame.
- `overrun`  output  1: a good byte completed while `rdy` was still 1; sticky.

## Operation
- `rx` passes through a 2-flop synchronizer. All FSM decisions use the synchronized `rx_s`.
- The FSM, sample counter `smp` (log2 OS_RATE bits) and bit index `bidx` (log2 DATA_BITS bits) advance only on cycles with `rxclk_en`=1. Otherwise they hold.
- IDLE:
  - `rx_s`=0 on a tick → START, with `smp`=0.
- START:
  - Each tick: if `rx_s`=1, return to IDLE (glitch reject).
  - Otherwise, at `smp`=OS_RATE/2−1 (mid start bit), go to DATA with `smp`=0 and `bidx`=0.
  - Otherwise increment `smp`.
- DATA:
  - `smp` increments each tick.
  - At `smp`=OS_RATE−1, shift `rx_s` into the MSB of the shift register (LSB-first reception) and wrap `smp` to 0.
  - After the bit with `bidx`=DATA_BITS−1 → STOP. Otherwise `bidx`++.
- STOP:
  - At `smp`=OS_RATE−1, sample `rx_s`, then go to IDLE.
  - If the sample is 1: load `data` from the shift register, set `rdy`, clear `frame_err`. If `rdy` was already 1 and no `rdy_clr` arrives in the same cycle, also set `overrun`.
  - If the sample is 0: set `frame_err`, leave `data` and `rdy` unchanged.
- A held-low line (break) produces repeated frame errors; no other action is taken.
- `rdy_clr`:
  - Clears `rdy` and `overrun` on the next edge.
  - If `rdy_clr` coincides with a good-frame load, the load wins: `rdy`=1, `overrun` not set.
- Reset value of every output is 0, FSM goes to IDLE, and the synchronizer flops reset to 1 (idle line). Reset mid-frame discards the partial byte.

## Timing
- Synchronizer latency: 2 `clk_50m` cycles from `rx` to `rx_s`.
- The start-edge decision is quantized to one tick period; sampling lands within ±1 tick of the bit centre.
- The start-bit midpoint check occurs on the OS_RATE/2-th tick after the falling edge is seen. Each data bit and the stop bit are sampled OS_RATE ticks after the previous sample.
- `data`, `rdy` and `frame_err` update on the `clk_50m` edge that ends the stop-sample tick cycle, i.e. 1 cycle after that tick is high.
- The receiver returns to IDLE on the same edge, so a start bit immediately following the stop midpoint is accepted (back-to-back frames).
- All outputs are registered; there are no combinational paths from `rx` or `rdy_clr` to any output.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`.
  - Constants `UART_OS_RATE`=16 and `UART_DATA_BITS`=8, shared with the transmitter.
- Sub-module `sync_2ff`: 2-flop synchronizer with a reset-value parameter, reused for other asynchronous inputs.
- The FSM, counters, shift register and flag logic sit in one `always_ff` block, with next-state logic in `always_comb`.

## Test plan
- Bench drives `rxclk_en` every 4 clocks with OS_RATE=16 (64 clocks/bit).
- Send 0xA5 framed 8N1 → `data`=0xA5, `rdy`=1 within 2+1 cycles of the 8th tick of the stop bit, `frame_err`=0.
- Send 0x00 then 0xFF back-to-back with no idle gap, pulsing `rdy_clr` after each → both bytes received, `overrun`=0.
- Pulse `rx` low for 3 ticks, then high → FSM returns to IDLE, `rdy` stays 0, no data change.
- Send 0x3C with the stop bit driven low → `frame_err`=1, `rdy`=0, `data` keeps its previous value. A following good 0x11 → `frame_err`=0, `data`=0x11.
- Send 0x55 then 0x66 without `rdy_clr` → `data`=0x66, `rdy`=1, `overrun`=1. Then `rdy_clr` → both clear next cycle. Repeat with `rdy_clr` coincident with the load → `overrun`=0.
- Assert `rst` during DATA bit 4 of a frame, release it, then send 0x81 → all outputs read 0 during reset, and 0x81 is received correctly.
